// File: rtl/stall_ctrl_if.sv
// Pipeline <-> stall controller signal bundle.
// master: pipeline side (drives hazard/request inputs, receives stall controls).
// slave : stall_ctrl.
`ifndef RegAddr
`define RegAddr 4:0
`endif

interface stall_ctrl_if;
  logic           id_read1_en;
  logic [`RegAddr] id_read1_addr;
  logic           id_read2_en;
  logic [`RegAddr] id_read2_addr;
  logic           exe_mem_read;
  logic [`RegAddr] exe_reg_addr;
  logic           mem_ram_req;
  logic           hold;
  logic           pc_hold;
  logic           if_id_hold;
  logic           if_id_bubble;

  modport master (
    output id_read1_en, id_read1_addr, id_read2_en, id_read2_addr,
    output exe_mem_read, exe_reg_addr, mem_ram_req,
    input  hold, pc_hold, if_id_hold, if_id_bubble
  );

  modport slave (
    input  id_read1_en, id_read1_addr, id_read2_en, id_read2_addr,
    input  exe_mem_read, exe_reg_addr, mem_ram_req,
    output hold, pc_hold, if_id_hold, if_id_bubble
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: load-use hazard bubbles plus structural stalls
// while the MEM stage borrows the shared instruction RAM.
// Optional macro STALL_CNT_EN adds the saturating stall_cycles counter port.
module stall_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  stall_ctrl_if.slave bus
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  // wcnt holds the WAIT cycles still owed, including the current one; a
  // re-arm in the last owed cycle owes a full MEM_WAIT further cycles.
  localparam logic [3:0] WAIT_LOAD  = 4'(MEM_WAIT - 1);
  localparam logic [3:0] REARM_LOAD = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wcnt;
  logic       load_use;
  logic       struct_stall;

  // Hazard detection and structural-stall request, both same-cycle.
  always_comb begin
    load_use = bus.exe_mem_read &&
               ((bus.id_read1_en && (bus.id_read1_addr == bus.exe_reg_addr)) ||
                (bus.id_read2_en && (bus.id_read2_addr == bus.exe_reg_addr)));
    struct_stall = (state == WAIT) || bus.mem_ram_req;
  end

  // Stall controls; load-use hold takes priority over the fetch bubble, and
  // reset forces everything low without waiting for a clock edge.
  always_comb begin
    bus.hold         = !rst && load_use;
    bus.if_id_hold   = !rst && load_use;
    bus.pc_hold      = !rst && (load_use || struct_stall);
    bus.if_id_bubble = !rst && struct_stall && !load_use;
  end

  // Instruction-RAM wait FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_ram_req && (MEM_WAIT > 1)) begin
            state <= WAIT;
            wcnt  <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wcnt == 4'd1) begin
            if (bus.mem_ram_req) begin
              wcnt <= REARM_LOAD;
            end else begin
              state <= IDLE;
              wcnt  <= '0;
            end
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.pc_hold && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
